hilo_unit: RTL and testbench
============================

# hilo_unit

Holds the architectural HI/LO registers of the MIPS datapath and sits directly downstream of the ALU. It latches the 64-bit `{Hi, Lo}` product the ALU produces for `mult`, and services `mthi`/`mtlo`. It also runs a multi-cycle signed/unsigned divider (`div`/`divu`) that writes remainder to HI and quotient to LO. `Busy` stalls the pipeline while a divide is in progress.

## Interface
- No parameters; datapath width fixed at 32.
- `clk` in 1 — single clock, all state updates on rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `HiIn` in 32 — ALU Hi output (upper product word).
- `LoIn` in 32 — ALU Lo output (lower product word).
- `SrcA` in 32 — dividend for div/divu; write data for mthi/mtlo.
- `SrcB` in 32 — divisor for div/divu.
- `HiLoOp` in 3 — command:
  - 0 = none
  - 1 = mult write
  - 2 = div (signed)
  - 3 = divu
  - 4 = mthi
  - 5 = mtlo
  - 6, 7 = none
- `Hi` out 32 — HI register.
- `Lo` out 32 — LO register.
- `Busy` out 1 — divide in progress; commands ignored while high.
- `Done` out 1 — one-cycle pulse when a divide result is written.

## Operation
- States: IDLE, DIV, FIX.
- **IDLE**, command sampled each edge:
  - op 1: Hi<=HiIn, Lo<=LoIn.
  - op 4: Hi<=SrcA, Lo unchanged.
  - op 5: Lo<=SrcA, Hi unchanged.
  - op 2/3 with SrcB≠0:
    - capture operands; for op 2, use |SrcA| and |SrcB|, and record qneg=SrcA[31]^SrcB[31] and rneg=SrcA[31];
    - clear partial remainder; counter<=0; Busy<=1; go DIV.
  - op 2/3 with SrcB==0:
    - Busy<=1; go FIX with result preset Hi=SrcA, Lo=32'hFFFFFFFF;
    - no sign correction.
- **DIV**: one restoring step per cycle.
  - trial = {rem[30:0], dividend MSB} − divisor, evaluated as 33-bit;
  - if non-negative, rem<=trial and shift in 1; else shift in 0;
  - dividend shifts left one bit.
  - After 32 steps (counter==31), go FIX.
- **FIX**:
  - Lo<=qneg ? −quotient : quotient; Hi<=rneg ? −remainder : remainder (negation only for op 2);
  - Done<=1 for this one edge's output; Busy<=0; go IDLE.
- Signed overflow 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0. This falls out of the magnitude path; no special case.
- Hi/Lo hold their previous values throughout DIV; only FIX updates them.
- Commands arriving while Busy=1 are ignored. The pipeline is responsible for holding them.

## Timing
- Reset (async, any state): Hi=0, Lo=0, Busy=0, Done=0, state=IDLE, counter=0. An in-flight divide is abandoned with no write.
- op 1/4/5: result visible on Hi/Lo one cycle after the sampling edge.
- Divide accepted at edge E0: Busy high from E0, 32 DIV edges E1..E32, FIX at E33.
  - Hi/Lo and Done=1 valid after E33; Busy low after E33; Done low after E34.
  - Total: 33 cycles Busy, 34 cycles from command to result.
- Divide-by-zero accepted at E0: FIX at E1; result and Done after E1; Busy high for exactly one cycle.
- Back-to-back: a new command is accepted on the edge after Busy falls (E34 for a normal divide).
- Done and Busy are never both high.

## Test plan
- Reset mid-divide (assert reset_n=0 at E10 of a divu) -> Hi=0, Lo=0, Busy=0, Done=0 immediately. A subsequent op 4 with SrcA=5 gives Hi=5.
- op 1 with HiIn=0x00000001, LoIn=0x80000000 -> next cycle Hi=0x00000001, Lo=0x80000000. Then op 5 with SrcA=0xDEADBEEF -> Lo=0xDEADBEEF, Hi unchanged.
- divu SrcA=100, SrcB=7 -> Busy high 33 cycles, Done pulse at cycle 34, Hi=2, Lo=14. An op 4 held during Busy has no effect.
- div SrcA=0xFFFFFFF9 (−7), SrcB=2 -> Lo=0xFFFFFFFD (−3), Hi=0xFFFFFFFF (−1). Also div 7/−2 -> Lo=0xFFFFFFFD, Hi=1.
- divu SrcA=0x12345678, SrcB=0 -> Busy for 1 cycle; Hi=0x12345678, Lo=0xFFFFFFFF, Done one cycle.
- div 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0. Then divu 0xFFFFFFFF/1 issued on the first non-Busy cycle -> Lo=0xFFFFFFFF, Hi=0.

Source files
------------

// File: rtl/hilo_unit_if.sv
// rtl/hilo_unit_if.sv - command/result bundle between the pipeline and the HI/LO unit
//
// Purpose: groups the ALU product words, divide operands, command code and
//          HI/LO/Busy/Done results so the unit takes a single bus port.
// Signals:
//   HiIn, LoIn  - ALU upper/lower product words (mult write)
//   SrcA        - dividend for div/divu, write data for mthi/mtlo
//   SrcB        - divisor for div/divu
//   HiLoOp      - command code (0 none, 1 mult, 2 div, 3 divu, 4 mthi, 5 mtlo)
//   Hi, Lo      - architectural HI/LO registers
//   Busy        - divide in progress, commands ignored
//   Done        - one-cycle pulse when a divide result is written
// Modports: master drives commands (pipeline), slave is the HI/LO unit.

interface hilo_unit_if;
  logic [31:0] HiIn;
  logic [31:0] LoIn;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [2:0]  HiLoOp;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        Done;

  modport master (
    output HiIn, LoIn, SrcA, SrcB, HiLoOp,
    input  Hi, Lo, Busy, Done
  );

  modport slave (
    input  HiIn, LoIn, SrcA, SrcB, HiLoOp,
    output Hi, Lo, Busy, Done
  );
endinterface

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - MIPS HI/LO registers with mult latch, mthi/mtlo and multi-cycle divider
//
// Purpose: holds HI/LO downstream of the ALU, latches the ALU product on mult,
//          services mthi/mtlo, and runs a 32-step restoring divider for
//          div/divu (remainder -> HI, quotient -> LO).
// Ports:
//   clk     - single clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - hilo_unit_if.slave (HiIn, LoIn, SrcA, SrcB, HiLoOp in;
//             Hi, Lo, Busy, Done out)

module hilo_unit (
  input  logic         clk,
  input  logic         reset_n,
  hilo_unit_if.slave   bus
);

  localparam logic [2:0] OP_MULT = 3'd1;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_DIVU = 3'd3;
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      state, state_nxt;

  logic [31:0] hi_q, lo_q;
  logic [31:0] dvd_q;      // dividend magnitude, shifted out MSB-first
  logic [31:0] dvs_q;      // divisor magnitude
  logic [31:0] rem_q;      // partial remainder
  logic [31:0] quo_q;      // quotient, shifted in LSB-first
  logic [4:0]  cnt_q;
  logic        qneg_q, rneg_q;
  logic        busy_q, done_q;

  logic        is_div, is_signed, div_zero;
  logic [31:0] abs_a, abs_b;
  logic [32:0] trial;

  always_comb begin
    is_div    = (bus.HiLoOp == OP_DIV) || (bus.HiLoOp == OP_DIVU);
    is_signed = (bus.HiLoOp == OP_DIV);
    div_zero  = (bus.SrcB == 32'd0);
    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude, so the overflow case needs no special path.
    abs_a     = (is_signed && bus.SrcA[31]) ? (~bus.SrcA + 32'd1) : bus.SrcA;
    abs_b     = (is_signed && bus.SrcB[31]) ? (~bus.SrcB + 32'd1) : bus.SrcB;
    // rem_q[31] is always 0 before a shift (the partial remainder is bounded
    // by the consumed dividend prefix), so dropping it loses nothing.
    trial     = {1'b0, rem_q[30:0], dvd_q[31]} - {1'b0, dvs_q};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (is_div) state_nxt = div_zero ? S_FIX : S_DIV;
      S_DIV:   if (cnt_q == 5'd31) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      dvd_q  <= 32'd0;
      dvs_q  <= 32'd0;
      rem_q  <= 32'd0;
      quo_q  <= 32'd0;
      cnt_q  <= 5'd0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          case (bus.HiLoOp)
            OP_MULT: begin
              hi_q <= bus.HiIn;
              lo_q <= bus.LoIn;
            end
            OP_MTHI: hi_q <= bus.SrcA;
            OP_MTLO: lo_q <= bus.SrcA;
            OP_DIV, OP_DIVU: begin
              busy_q <= 1'b1;
              if (div_zero) begin
                // Preset the result and let FIX write it unmodified.
                rem_q  <= bus.SrcA;
                quo_q  <= 32'hFFFF_FFFF;
                qneg_q <= 1'b0;
                rneg_q <= 1'b0;
              end else begin
                dvd_q  <= abs_a;
                dvs_q  <= abs_b;
                rem_q  <= 32'd0;
                quo_q  <= 32'd0;
                cnt_q  <= 5'd0;
                qneg_q <= is_signed && (bus.SrcA[31] ^ bus.SrcB[31]);
                rneg_q <= is_signed && bus.SrcA[31];
              end
            end
            default: ;
          endcase
        end
        S_DIV: begin
          if (!trial[32]) begin
            rem_q <= trial[31:0];
            quo_q <= {quo_q[30:0], 1'b1};
          end else begin
            rem_q <= {rem_q[30:0], dvd_q[31]};
            quo_q <= {quo_q[30:0], 1'b0};
          end
          dvd_q <= {dvd_q[30:0], 1'b0};
          cnt_q <= cnt_q + 5'd1;
        end
        S_FIX: begin
          lo_q   <= qneg_q ? (~quo_q + 32'd1) : quo_q;
          hi_q   <= rneg_q ? (~rem_q + 32'd1) : rem_q;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.Hi   = hi_q;
  assign bus.Lo   = lo_q;
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - directed self-checking bench for hilo_unit

module tb_hilo_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  hilo_unit_if bus ();

  hilo_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one command for exactly one sampling edge, then return to op 0.
  task automatic cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] hin, input logic [31:0] lin);
    bus.HiLoOp = op;
    bus.SrcA   = a;
    bus.SrcB   = b;
    bus.HiIn   = hin;
    bus.LoIn   = lin;
    tick();
    bus.HiLoOp = 3'd0;
  endtask

  // Called just after the accepting edge; returns just after the FIX edge.
  task automatic wait_div(input string tag, input int exp_cycles,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic hold);
    int          cyc;
    logic [31:0] hi0;
    logic [31:0] lo0;
    logic        overlap;
    logic        moved;
    cyc     = 0;
    hi0     = bus.Hi;
    lo0     = bus.Lo;
    overlap = 1'b0;
    moved   = 1'b0;
    while (bus.Busy === 1'b1 && cyc < 200) begin
      cyc++;
      if (bus.Done !== 1'b0) overlap = 1'b1;
      if (bus.Hi !== hi0 || bus.Lo !== lo0) moved = 1'b1;
      if (hold) begin
        bus.HiLoOp = 3'd4;
        bus.SrcA   = 32'h5555_AAAA;
      end
      tick();
    end
    bus.HiLoOp = 3'd0;
    check({tag, "_busy_cycles"}, cyc, exp_cycles);
    check({tag, "_busy_done_overlap"}, {31'd0, overlap}, 32'd0);
    check({tag, "_hilo_held"}, {31'd0, moved}, 32'd0);
    check({tag, "_done"}, {31'd0, bus.Done}, 32'd1);
    check({tag, "_hi"}, bus.Hi, exp_hi);
    check({tag, "_lo"}, bus.Lo, exp_lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.HiIn   = 32'd0;
    bus.LoIn   = 32'd0;
    bus.SrcA   = 32'd0;
    bus.SrcB   = 32'd0;
    bus.HiLoOp = 3'd0;
    tick();
    tick();
    check("rst_hi", bus.Hi, 32'd0);
    check("rst_lo", bus.Lo, 32'd0);
    check("rst_busy", {31'd0, bus.Busy}, 32'd0);
    check("rst_done", {31'd0, bus.Done}, 32'd0);
    reset_n = 1'b1;
    tick();

    // mult write, then mtlo
    cmd(3'd1, 32'd0, 32'd0, 32'h0000_0001, 32'h8000_0000);
    check("mult_hi", bus.Hi, 32'h0000_0001);
    check("mult_lo", bus.Lo, 32'h8000_0000);
    cmd(3'd5, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0);
    check("mtlo_lo", bus.Lo, 32'hDEAD_BEEF);
    check("mtlo_hi", bus.Hi, 32'h0000_0001);
    cmd(3'd6, 32'h1111_1111, 32'd0, 32'h2222_2222, 32'h3333_3333);
    check("op6_hi", bus.Hi, 32'h0000_0001);
    check("op6_lo", bus.Lo, 32'hDEAD_BEEF);

    // reset in the middle of a divu
    cmd(3'd3, 32'd100, 32'd7, 32'd0, 32'd0);
    repeat (9) tick();
    check("middiv_busy", {31'd0, bus.Busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("middiv_rst_hi", bus.Hi, 32'd0);
    check("middiv_rst_lo", bus.Lo, 32'd0);
    check("middiv_rst_busy", {31'd0, bus.Busy}, 32'd0);
    check("middiv_rst_done", {31'd0, bus.Done}, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    cmd(3'd4, 32'd5, 32'd0, 32'd0, 32'd0);
    check("mthi_after_rst", bus.Hi, 32'd5);
    check("mthi_after_rst_busy", {31'd0, bus.Busy}, 32'd0);

    // divu 100/7 with an mthi held during Busy
    cmd(3'd3, 32'd100, 32'd7, 32'd0, 32'd0);
    wait_div("divu_100_7", 33, 32'd2, 32'd14, 1'b1);
    tick();
    check("divu_100_7_done_low", {31'd0, bus.Done}, 32'd0);

    // signed divides
    cmd(3'd2, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
    wait_div("div_m7_2", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    tick();
    cmd(3'd2, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd0);
    wait_div("div_7_m2", 33, 32'd1, 32'hFFFF_FFFD, 1'b0);
    tick();

    // divide by zero
    cmd(3'd3, 32'h1234_5678, 32'd0, 32'd0, 32'd0);
    wait_div("divu_by0", 1, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
    tick();
    check("divu_by0_done_low", {31'd0, bus.Done}, 32'd0);

    // signed overflow, then back-to-back divu on the first non-Busy edge
    cmd(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);
    wait_div("div_ovf", 33, 32'd0, 32'h8000_0000, 1'b0);
    cmd(3'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    check("b2b_accept_busy", {31'd0, bus.Busy}, 32'd1);
    check("b2b_accept_done", {31'd0, bus.Done}, 32'd0);
    wait_div("divu_max_1", 33, 32'd0, 32'hFFFF_FFFF, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
